mem_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined datapath. It latches one request at a time, drives the RAM until the RAM reports an access, returns an `ihit` or `dhit` pulse with the load data, and then returns to idle. Data requests have priority. A starvation counter guarantees forward progress for instruction fetch. The block sits between the cache/datapath interface and the RAM model.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port between instruction fetch and data memory.
//   One request is latched at a time. The arbiter drives the RAM until the
//   RAM reports ACCESS, returns a one-cycle ihit/dhit with the load data,
//   and then goes back to IDLE. Data has priority, but a streak counter
//   hands the port to a waiting fetch after STARVE_LIMIT data grants.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   iREN, iaddr          instruction read request / address
//   dREN, dWEN           data read / write request (write wins if both)
//   daddr, dstore        data address / write value
//   ihit, iload          fetch complete pulse / instruction word
//   dhit, dload          data complete pulse / read value (0 on writes)
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//
// state  | meaning
// IDLE   | no grant; arbitrate between requesters every cycle
// IGRANT | instruction fetch owns the RAM
// DGRANT | data access owns the RAM

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int          STREAK_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t                state;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_data;
    logic                  lat_wr;
    logic [STREAK_W-1:0]   streak;

    logic d_req;
    logic starve;
    logic ram_access;

    assign d_req      = dREN | dWEN;
    assign starve     = iREN && (streak == LIMIT);
    assign ram_access = (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            streak   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starve) begin
                        state    <= DGRANT;
                        lat_addr <= daddr;
                        lat_data <= dstore;
                        lat_wr   <= dWEN;
                        // Only count grants that made a fetch wait.
                        if (iREN && (streak != LIMIT))
                            streak <= streak + 1'b1;
                    end else if (iREN) begin
                        state    <= IGRANT;
                        lat_addr <= iaddr;
                        lat_wr   <= 1'b0;
                        streak   <= '0;
                    end
                end
                // ACCESS completes; a dropped request aborts. ERROR retries.
                IGRANT: if (ram_access || !iREN)  state <= IDLE;
                DGRANT: if (ram_access || !d_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state so that an async reset clears them
    // immediately and an abort drops the strobes in the same cycle.
    always_comb begin
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGRANT: begin
                ramaddr = lat_addr;
                ramREN  = iREN | ram_access;
                ihit    = ram_access;
                iload   = ram_access ? ramload : '0;
            end
            DGRANT: begin
                ramaddr  = lat_addr;
                ramstore = lat_data;
                ramWEN   = lat_wr & (d_req | ram_access);
                ramREN   = !lat_wr & (d_req | ram_access);
                dhit     = ram_access;
                dload    = (ram_access && !lat_wr) ? ramload : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well away from the edge.

module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = FREE;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ren"},  32'(ramREN), 0);
        check({tag, "_wen"},  32'(ramWEN), 0);
        check({tag, "_ihit"}, 32'(ihit), 0);
        check({tag, "_dhit"}, 32'(dhit), 0);
    endtask

    logic [7:0] seq[$];
    logic [7:0] exp_seq[6];
    int         dcount;
    logic       done;

    initial begin
        exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44}; // D D D D I D

        // Reset state
        #12;
        check_idle("rst");
        check("rst_addr", ramaddr, 0);
        check("rst_streak", 32'(dut.streak), 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Single fetch, ACCESS in 2nd grant cycle
        tick;
        iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
        #1 check("f_idle_ren", 32'(ramREN), 0);
        tick;
        ramstate = BUSY;
        #1 check("f_c1_ren", 32'(ramREN), 1);
        check("f_c1_addr", ramaddr, 32'h40);
        check("f_c1_ihit", 32'(ihit), 0);
        tick;
        ramstate = ACCESS; ramload = 32'h8C010004;
        #1 check("f_c2_ren", 32'(ramREN), 1);
        check("f_c2_addr", ramaddr, 32'h40);
        check("f_c2_ihit", 32'(ihit), 1);
        check("f_c2_iload", iload, 32'h8C010004);
        check("f_c2_dhit", 32'(dhit), 0);
        tick;
        iREN = 1'b0; ramstate = FREE;
        #1 check_idle("f_after");
        check("f_after_iload", iload, 0);

        // Priority: data first, then fetch after an IDLE cycle
        tick;
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        tick;
        ramstate = ACCESS; ramload = 32'h11;
        #1 check("p_d_ren", 32'(ramREN), 1);
        check("p_d_addr", ramaddr, 32'h100);
        check("p_d_dhit", 32'(dhit), 1);
        check("p_d_dload", dload, 32'h11);
        check("p_d_ihit", 32'(ihit), 0);
        check("p_streak", 32'(dut.streak), 1);
        tick;
        dREN = 1'b0; ramstate = FREE;
        #1 check_idle("p_turn");
        tick;
        ramstate = ACCESS; ramload = 32'h22;
        #1 check("p_i_addr", ramaddr, 32'h44);
        check("p_i_ihit", 32'(ihit), 1);
        check("p_i_iload", iload, 32'h22);
        tick;
        iREN = 1'b0; ramstate = FREE;
        #1 check_idle("p_after");
        check("p_streak_clr", 32'(dut.streak), 0);

        // Write with 3 BUSY cycles
        tick;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        tick;
        for (int c = 0; c < 3; c++) begin
            ramstate = BUSY;
            #1 check("w_busy_wen", 32'(ramWEN), 1);
            check("w_busy_ren", 32'(ramREN), 0);
            check("w_busy_store", ramstore, 32'hDEADBEEF);
            check("w_busy_addr", ramaddr, 32'h200);
            check("w_busy_dhit", 32'(dhit), 0);
            tick;
        end
        ramstate = ACCESS; ramload = 32'h55;
        #1 check("w_acc_wen", 32'(ramWEN), 1);
        check("w_acc_ren", 32'(ramREN), 0);
        check("w_acc_dhit", 32'(dhit), 1);
        check("w_acc_dload", dload, 0);
        tick;
        dWEN = 1'b0; ramstate = FREE;
        #1 check_idle("w_after");

        // Starvation: fetch waits through 4 data grants
        tick;
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h400;
        ramstate = ACCESS; ramload = 32'h77;
        dcount = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick;
            #1;
            if (ihit && dhit) check("s_both_hit", 1, 0);
            if (dhit) begin
                seq.push_back(8'h44);
                dcount++;
                if (dcount == 5) dREN = 1'b0;
            end
            if (ihit) begin
                seq.push_back(8'h49);
                iREN = 1'b0;
            end
            done = !iREN && !dREN;
        end
        check("s_done", 32'(done), 1);
        check("s_count", 32'(seq.size()), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("s_seq%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'h0, 32'(exp_seq[i]));
        tick;
        ramstate = FREE;
        #1 check_idle("s_after");

        // ERROR retries with strobes held
        tick;
        iREN = 1'b1; iaddr = 32'h80;
        tick;
        for (int c = 0; c < 2; c++) begin
            ramstate = ERROR;
            #1 check("e_ren", 32'(ramREN), 1);
            check("e_ihit", 32'(ihit), 0);
            tick;
        end
        ramstate = ACCESS; ramload = 32'h33;
        #1 check("e_ihit_acc", 32'(ihit), 1);
        check("e_iload", iload, 32'h33);
        tick;
        iREN = 1'b0; ramstate = FREE;
        #1 check_idle("e_after");

        // Abort: fetch drops while BUSY
        tick;
        iREN = 1'b1; iaddr = 32'h90;
        tick;
        ramstate = BUSY;
        #1 check("a_ren", 32'(ramREN), 1);
        tick;
        iREN = 1'b0;
        #1 check("a_drop_ren", 32'(ramREN), 0);
        check("a_drop_ihit", 32'(ihit), 0);
        tick;
        ramstate = ACCESS;
        #1 check_idle("a_after");
        tick;
        ramstate = FREE;

        // Reset mid-grant during a data write, with a fetch waiting
        tick;
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h5;
        tick;
        ramstate = BUSY;
        #1 check("r_wen", 32'(ramWEN), 1);
        check("r_streak", 32'(dut.streak), 1);
        ramstate = ACCESS;
        #1 nRST = 1'b0;
        #1 check("r_async_wen", 32'(ramWEN), 0);
        check("r_async_dhit", 32'(dhit), 0);
        check("r_async_store", ramstore, 0);
        iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick;
        tick;
        nRST = 1'b1;
        tick;
        #1 check_idle("r_after");
        check("r_state", 32'(dut.state), 0);
        check("r_streak_clr", 32'(dut.streak), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
